// File: rtl/activation_unit.sv
// activation_unit: fixed-point (signed Q8.8) activation stage.
// Computes sigmoid, tanh, ReLU or identity using shift-and-add
// piecewise-linear arithmetic (no multipliers). Every request walks
// IDLE -> ABS -> SEG -> POST, so all functions share the same latency
// of three edges from accept to result, and one result per four cycles.
module activation_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_valid,
    input  logic [WIDTH-1:0] activate_in,
    input  logic [1:0]       activate_ctrl,
    output logic             act_in_ready,
    output logic [WIDTH-1:0] activate_out,
    output logic             activate_ready,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ABS  = 2'd1;
    localparam logic [1:0] ST_SEG  = 2'd2;
    localparam logic [1:0] ST_POST = 2'd3;

    localparam logic [1:0] FN_SIGMOID  = 2'b00;
    localparam logic [1:0] FN_TANH     = 2'b01;
    localparam logic [1:0] FN_RELU     = 2'b10;
    localparam logic [1:0] FN_IDENTITY = 2'b11;

    // 2*v with saturation to the Q8.8 extremes (tanh argument pre-scale).
    function automatic logic [15:0] sat_double(input logic [15:0] v);
        logic [15:0] r;
        if (v[15] != v[14]) begin
            r = v[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            r = {v[14:0], 1'b0};
        end
        return r;
    endfunction

    // |v| with the single unrepresentable case (-128.0) clamped to 0x7FFF.
    function automatic logic [15:0] abs_sat(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'h8000) begin
            r = 16'h7FFF;
        end else if (v[15]) begin
            r = 16'h0000 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Piecewise-linear sigmoid for a non-negative magnitude; lower
    // thresholds are inclusive.
    function automatic logic [15:0] sig_mag(input logic [15:0] m);
        logic [15:0] r;
        if (m >= 16'h0500) begin
            r = 16'h0100;
        end else if (m >= 16'h0260) begin
            r = (m >> 5) + 16'h00D8;
        end else if (m >= 16'h0100) begin
            r = (m >> 3) + 16'h00A0;
        end else begin
            r = (m >> 2) + 16'h0080;
        end
        return r;
    endfunction

    logic [1:0]  state_r;
    logic [15:0] x_r;
    logic [1:0]  ctrl_r;
    logic        sign_r;
    logic [15:0] mag_r;
    logic [15:0] y_r;
    logic [15:0] out_r;
    logic        ready_r;
    logic        in_ready_r;
    logic        busy_r;

    logic [15:0] abs_src_s;
    logic [15:0] sig_s;
    logic [15:0] post_s;

    // Select the value whose sign/magnitude feeds the sigmoid core.
    always_comb begin
        abs_src_s = x_r;
        if (ctrl_r == FN_TANH) begin
            abs_src_s = sat_double(x_r);
        end else begin
            abs_src_s = x_r;
        end
    end

    // Final result: mirror the sigmoid for negative inputs, then map per function.
    always_comb begin
        sig_s  = 16'h0000;
        post_s = 16'h0000;
        if (sign_r) begin
            sig_s = 16'h0100 - y_r;
        end else begin
            sig_s = y_r;
        end
        case (ctrl_r)
            FN_SIGMOID:  post_s = sig_s;
            FN_TANH:     post_s = {sig_s[14:0], 1'b0} - 16'h0100;
            FN_RELU:     post_s = x_r[15] ? 16'h0000 : x_r;
            FN_IDENTITY: post_s = x_r;
            default:     post_s = x_r;
        endcase
    end

    // Request FSM, datapath pipeline registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            x_r        <= 16'h0000;
            ctrl_r     <= 2'b00;
            sign_r     <= 1'b0;
            mag_r      <= 16'h0000;
            y_r        <= 16'h0000;
            out_r      <= 16'h0000;
            ready_r    <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (act_valid) begin
                        x_r        <= activate_in;
                        ctrl_r     <= activate_ctrl;
                        state_r    <= ST_ABS;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_ABS: begin
                    sign_r  <= abs_src_s[15];
                    mag_r   <= abs_sat(abs_src_s);
                    state_r <= ST_SEG;
                end
                ST_SEG: begin
                    y_r     <= sig_mag(mag_r);
                    state_r <= ST_POST;
                end
                ST_POST: begin
                    out_r      <= post_s;
                    ready_r    <= 1'b1;
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign act_in_ready   = in_ready_r;
    assign activate_out   = out_r;
    assign activate_ready = ready_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit.
module tb_activation_unit;

    logic        clk;
    logic        rst;
    logic        act_valid;
    logic [15:0] activate_in;
    logic [1:0]  activate_ctrl;
    logic        act_in_ready;
    logic [15:0] activate_out;
    logic        activate_ready;
    logic        busy;

    int n_checks;
    int n_pass;

    activation_unit #(.WIDTH(16), .FRAC(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .act_valid      (act_valid),
        .activate_in    (activate_in),
        .activate_ctrl  (activate_ctrl),
        .act_in_ready   (act_in_ready),
        .activate_out   (activate_out),
        .activate_ready (activate_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; checks result value, pulse position (3 edges after accept) and width.
    task automatic run_req(input string tag, input logic [1:0] c, input logic [15:0] d,
                           input logic [15:0] exp);
        int ready_cycle;
        int ready_cnt;
        @(negedge clk);
        check_eq({tag, ".in_ready"}, {15'd0, act_in_ready}, 16'd1);
        act_valid     = 1'b1;
        activate_in   = d;
        activate_ctrl = c;
        @(posedge clk);
        @(negedge clk);
        act_valid     = 1'b0;
        activate_in   = ~d;
        activate_ctrl = ~c;
        check_eq({tag, ".busy"}, {15'd0, busy}, 16'd1);
        ready_cycle = 0;
        ready_cnt   = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (activate_ready) begin
                ready_cnt++;
                if (ready_cycle == 0) ready_cycle = k;
            end
        end
        check_eq({tag, ".out"}, activate_out, exp);
        check_eq({tag, ".pulse_at"}, 16'(ready_cycle), 16'd3);
        check_eq({tag, ".pulse_len"}, 16'(ready_cnt), 16'd1);
    endtask

    logic [17:0] vec [12];
    logic [15:0] bexp [3];
    int          pulses;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        act_valid     = 1'b0;
        activate_in   = 16'h0000;
        activate_ctrl = 2'b00;
        #12;
        check_eq("rst.out", activate_out, 16'h0000);
        check_eq("rst.ready", {15'd0, activate_ready}, 16'd0);
        check_eq("rst.in_ready", {15'd0, act_in_ready}, 16'd1);
        check_eq("rst.busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sigmoid sweep
        run_req("sig_0000", 2'b00, 16'h0000, 16'h0080);
        run_req("sig_0080", 2'b00, 16'h0080, 16'h00A0);
        run_req("sig_0100", 2'b00, 16'h0100, 16'h00C0);
        run_req("sig_FF00", 2'b00, 16'hFF00, 16'h0040);
        run_req("sig_0300", 2'b00, 16'h0300, 16'h00F0);
        run_req("sig_0600", 2'b00, 16'h0600, 16'h0100);
        run_req("sig_FA00", 2'b00, 16'hFA00, 16'h0000);
        // Tanh
        run_req("tanh_0080", 2'b01, 16'h0080, 16'h0080);
        run_req("tanh_FF80", 2'b01, 16'hFF80, 16'hFF80);
        run_req("tanh_0300", 2'b01, 16'h0300, 16'h0100);
        run_req("tanh_8000", 2'b01, 16'h8000, 16'hFF00);
        run_req("tanh_0000", 2'b01, 16'h0000, 16'h0000);
        // ReLU / identity
        run_req("relu_FE00", 2'b10, 16'hFE00, 16'h0000);
        run_req("relu_0180", 2'b10, 16'h0180, 16'h0180);
        run_req("id_8000", 2'b11, 16'h8000, 16'h8000);
        run_req("id_1234", 2'b11, 16'h1234, 16'h1234);
        // Sigmoid segment edges
        run_req("sig_00FF", 2'b00, 16'h00FF, 16'h00BF);
        run_req("sig_025F", 2'b00, 16'h025F, 16'h00EB);
        run_req("sig_0260", 2'b00, 16'h0260, 16'h00EB);
        run_req("sig_04FF", 2'b00, 16'h04FF, 16'h00FF);
        run_req("sig_0500", 2'b00, 16'h0500, 16'h0100);

        // Back-to-back with act_valid held; non-accepted vectors would show as DEAD
        for (int j = 0; j < 12; j++) vec[j] = {2'b11, 16'hDEAD};
        vec[0] = {2'b00, 16'h0100};
        vec[4] = {2'b11, 16'h1234};
        vec[8] = {2'b10, 16'h0180};
        bexp[0] = 16'h00C0;
        bexp[1] = 16'h1234;
        bexp[2] = 16'h0180;
        @(negedge clk);
        check_eq("b2b.in_ready0", {15'd0, act_in_ready}, 16'd1);
        act_valid     = 1'b1;
        activate_ctrl = vec[0][17:16];
        activate_in   = vec[0][15:0];
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("b2b.ready%0d", j), {15'd0, activate_ready},
                     (j % 4 == 3) ? 16'd1 : 16'd0);
            if (j % 4 == 3) check_eq($sformatf("b2b.out%0d", j), activate_out, bexp[j / 4]);
            check_eq($sformatf("b2b.in_ready%0d", j), {15'd0, act_in_ready},
                     ((j + 1) % 4 == 0) ? 16'd1 : 16'd0);
            if (j < 11) begin
                activate_ctrl = vec[j + 1][17:16];
                activate_in   = vec[j + 1][15:0];
            end else begin
                act_valid = 1'b0;
            end
        end

        // Reset one cycle after accept aborts the request
        @(negedge clk);
        act_valid     = 1'b1;
        activate_ctrl = 2'b00;
        activate_in   = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        act_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort.out", activate_out, 16'h0000);
        check_eq("abort.in_ready", {15'd0, act_in_ready}, 16'd1);
        check_eq("abort.busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (activate_ready) pulses++;
        end
        check_eq("abort.no_pulse", 16'(pulses), 16'd0);
        run_req("after_abort", 2'b00, 16'h0080, 16'h00A0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Fixed-point activation stage directly downstream of the forward-propagation controller.
- Accepts a pre-activation value (data*weight+bias) and a 2-bit function select.
- Computes sigmoid, tanh, ReLU or identity using shift-and-add piecewise-linear arithmetic; no multipliers.
- Returns the result with a one-cycle ready pulse through a 3-stage multi-cycle FSM.

Parameters:
- WIDTH, 16, data width. Only 16 is supported.
- FRAC, 8, fractional bits. Format is signed Q8.8, so 1.0 = 0x0100. Only 8 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- act_valid  input  1  request strobe; a request is accepted when act_valid && act_in_ready
- activate_in  input  16  signed Q8.8 pre-activation value
- activate_ctrl  input  2  00 sigmoid, 01 tanh, 10 ReLU, 11 identity
- act_in_ready  output  1  high when the unit can accept a request (state IDLE)
- activate_out  output  16  signed Q8.8 result; held until the next result is produced
- activate_ready  output  1  one-cycle pulse when activate_out is updated
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async) values: state=IDLE, activate_out=0x0000, activate_ready=0, act_in_ready=1, busy=0. All internal registers clear.
- Reset mid-operation aborts the request in flight. No activate_ready pulse is issued for it.
- FSM states and transitions:
  - IDLE -> ABS on accept.
  - ABS -> SEG -> POST unconditionally.
  - POST -> IDLE unconditionally.
- Latency: accept at edge E0; activate_out and activate_ready are registered at E3; activate_ready is high E3..E4.
- Throughput: next accept possible at E4, i.e. one result per 4 cycles.
- act_valid in non-IDLE states is ignored, not queued. activate_in and activate_ctrl are latched only at accept; later changes have no effect.
- ABS stage:
  - Store sign = x[15] and mag = |x|.
  - |0x8000| saturates to 0x7FFF.
  - For tanh, first form x2 = 2x with saturation to 0x7FFF / 0x8000, then take its sign and magnitude.
- SEG stage, sigmoid magnitude y(m) for m >= 0, all unsigned 16-bit, unused high bits zero:
  - m >= 0x0500: y = 0x0100.
  - 0x0260 <= m < 0x0500: y = (m>>5) + 0x00D8.
  - 0x0100 <= m < 0x0260: y = (m>>3) + 0x00A0.
  - m < 0x0100: y = (m>>2) + 0x0080.
- POST stage:
  - Sigmoid: out = sign ? 0x0100 - y : y. Range is [0x0000, 0x0100].
  - Tanh: s = sigmoid result of x2 (as above); out = 2*s - 0x0100. Range is [0xFF00, 0x0100].
  - ReLU: out = x[15] ? 0x0000 : x.
  - Identity: out = x unchanged.
  - ReLU and identity still traverse all 3 stages, giving the same latency for every function.
- Boundaries:
  - Segment thresholds are inclusive at the lower bound.
  - Sigmoid(0) = 0x0080 and tanh(0) = 0x0000, independent of sign handling. -0 does not occur in two's complement.
- Simultaneous events: act_valid is asserted in the same cycle activate_ready is high. act_in_ready is already 1 in that cycle because state is IDLE, so the request is accepted.

Test Plan:
- Reset, then sigmoid sweep, one request each:
  - 0x0000 -> 0x0080
  - 0x0080 -> 0x00A0
  - 0x0100 -> 0x00C0
  - 0xFF00 -> 0x0040
  - 0x0300 -> 0x00F0
  - 0x0600 -> 0x0100
  - 0xFA00 -> 0x0000
  - Each activate_ready pulse is exactly 1 cycle, 3 cycles after accept.
- Tanh cases:
  - 0x0080 -> 0x0080
  - 0xFF80 -> 0xFF80
  - 0x0300 -> 0x0100
  - 0x8000 -> 0xFF00 (saturation path)
  - 0x0000 -> 0x0000
- ReLU/identity cases:
  - ReLU 0xFE00 -> 0x0000
  - ReLU 0x0180 -> 0x0180
  - Identity 0x8000 -> 0x8000
  - Identity 0x1234 -> 0x1234
- Back-to-back: hold act_valid high with changing data.
  - Accepts occur every 4 cycles; act_in_ready is low for 3 cycles after each accept.
  - Mid-flight changes to activate_in/activate_ctrl do not alter the in-flight result.
- Reset mid-op: assert rst one cycle after accepting sigmoid 0x0100.
  - activate_out=0x0000, no activate_ready pulse, act_in_ready=1 immediately.
  - The next request completes normally.
- Threshold edges for sigmoid:
  - 0x00FF -> 0x00BF
  - 0x025F -> 0x00EB
  - 0x0260 -> 0x00EB
  - 0x04FF -> 0x00FF
  - 0x0500 -> 0x0100
